hazard_ctrl: RTL and testbench

- Control-side producer for the pipeline-register enables and clears in the 5-stage MIPS core: it drives stallF/stallD (to enable-low), flushD/flushE (to clear), and the forwarding selects.
- Detects load-use, branch-compare and multi-cycle mult/div (HI/LO) hazards.
- Owns the only sequential state in hazard handling: an MDU busy countdown and a saturating stall-cycle counter.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/mdu_tracker.sv | 30 +++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the hazard / forwarding control slice.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero is hardwired, so a source of 0 never depends on an older write.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/mdu_tracker.sv
// Tracks how long a mult/div occupies the MDU after it enters Execute.
module mdu_tracker #(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic mdstartE,
    output logic mdu_busy,
    output logic mdu_done
);

    localparam int CNTW = $clog2(MDU_LAT + 1);
    localparam logic [CNTW-1:0] LAT_LD = CNTW'(MDU_LAT);

    logic [CNTW-1:0] cnt;

    // A start while busy reloads; the stall logic keeps that from happening.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (mdstartE)
            cnt <= LAT_LD;
        else if (cnt != '0)
            cnt <= cnt - CNTW'(1);
    end

    assign mdu_busy = ~reset & (cnt != '0);
    assign mdu_done = ~reset & (cnt == CNTW'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, stall/flush control, MDU tracking
// and a saturating count of stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    rsD,
    input  logic [4:0]    rtD,
    input  logic [4:0]    rsE,
    input  logic [4:0]    rtE,
    input  logic [4:0]    writeregE,
    input  logic [4:0]    writeregM,
    input  logic [4:0]    writeregW,
    input  logic          regwriteE,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          memtoregE,
    input  logic          memtoregM,
    input  logic          branchD,
    input  logic          pcsrcD,
    input  logic          mdstartD,
    input  logic          mdstartE,
    input  logic          hiloreadD,
    output logic          stallF,
    output logic          stallD,
    output logic          flushD,
    output logic          flushE,
    output logic          forwardAD,
    output logic          forwardBD,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic          mdu_busy,
    output logic          mdu_done,
    output logic [CW-1:0] stall_cnt
);

    logic lwstall;
    logic branchstall;
    logic mdustall;
    logic stall;

    mdu_tracker #(.MDU_LAT(MDU_LAT)) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .mdstartE (mdstartE),
        .mdu_busy (mdu_busy),
        .mdu_done (mdu_done)
    );

    always_comb begin
        lwstall     = 1'b0;
        branchstall = 1'b0;
        mdustall    = 1'b0;
        stall       = 1'b0;
        forwardAE   = FWD_REG;
        forwardBE   = FWD_REG;
        forwardAD   = 1'b0;
        forwardBD   = 1'b0;
        flushD      = 1'b0;

        if (!reset) begin
            // Memory stage is the newer result, so it beats writeback.
            if (regwriteM && reg_match(rsE, writeregM))
                forwardAE = FWD_MEM;
            else if (regwriteW && reg_match(rsE, writeregW))
                forwardAE = FWD_WB;

            if (regwriteM && reg_match(rtE, writeregM))
                forwardBE = FWD_MEM;
            else if (regwriteW && reg_match(rtE, writeregW))
                forwardBE = FWD_WB;

            forwardAD = regwriteM && reg_match(rsD, writeregM);
            forwardBD = regwriteM && reg_match(rtD, writeregM);

            lwstall = memtoregE &&
                      (reg_match(rsD, writeregE) || reg_match(rtD, writeregE));

            branchstall = branchD &&
                ((regwriteE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE))) ||
                 (memtoregM && (reg_match(rsD, writeregM) || reg_match(rtD, writeregM))));

            mdustall = (hiloreadD || mdstartD) && (mdu_busy || mdstartE);

            stall = lwstall || branchstall || mdustall;

            // A stalled branch re-evaluates next cycle, so it must not flush yet.
            flushD = pcsrcD && !stall;
        end
    end

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CW'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic          branchD, pcsrcD, mdstartD, mdstartE, hiloreadD;
    logic          stallF, stallD, flushD, flushE, forwardAD, forwardBD;
    logic [1:0]    forwardAE, forwardBE;
    logic          mdu_busy, mdu_done;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: cycle index, cycle of the latest MDU start,
    // and the ideal stall count.
    int cyc        = 0;
    int last_start = -1000;
    int m_scnt     = 0;

    logic       e_stall, e_flushD, e_fAD, e_fBD, e_busy, e_done;
    logic [1:0] e_fAE, e_fBE;

    hazard_ctrl #(.MDU_LAT(LAT), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rsD       (rsD),
        .rtD       (rtD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeregE (writeregE),
        .writeregM (writeregM),
        .writeregW (writeregW),
        .regwriteE (regwriteE),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .memtoregE (memtoregE),
        .memtoregM (memtoregM),
        .branchD   (branchD),
        .pcsrcD    (pcsrcD),
        .mdstartD  (mdstartD),
        .mdstartE  (mdstartE),
        .hiloreadD (hiloreadD),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushD    (flushD),
        .flushE    (flushE),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .mdu_busy  (mdu_busy),
        .mdu_done  (mdu_done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit dep(input logic [4:0] s, input logic [4:0] d);
        return (s != 0) && (s == d);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] s);
        if (regwriteM && dep(s, writeregM)) return 2'd2;
        if (regwriteW && dep(s, writeregW)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic void model_eval();
        int  age;
        bit  lw, br, md;
        age    = cyc - last_start;
        e_busy = !reset && age >= 1 && age <= LAT;
        e_done = !reset && age == LAT;
        e_fAE  = reset ? 2'd0 : fwd_sel(rsE);
        e_fBE  = reset ? 2'd0 : fwd_sel(rtE);
        e_fAD  = !reset && regwriteM && dep(rsD, writeregM);
        e_fBD  = !reset && regwriteM && dep(rtD, writeregM);
        lw = memtoregE && (dep(rsD, writeregE) || dep(rtD, writeregE));
        br = branchD && ((regwriteE && (dep(rsD, writeregE) || dep(rtD, writeregE))) ||
                         (memtoregM && (dep(rsD, writeregM) || dep(rtD, writeregM))));
        md = (hiloreadD || mdstartD) && (e_busy || mdstartE);
        e_stall  = !reset && (lw || br || md);
        e_flushD = !reset && pcsrcD && !e_stall;
    endfunction

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, pcsrcD, mdstartD, mdstartE, hiloreadD} = '0;
    endtask

    task automatic tick();
        model_eval();
        if (!reset) begin
            if (e_stall && m_scnt < SAT) m_scnt++;
            if (mdstartE) last_start = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        last_start = -1000;
        m_scnt     = 0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; rsD = 5'd3;
        memtoregE = 1'b1; writeregE = 5'd3; pcsrcD = 1'b1;
        @(negedge clk);
        total++;
        if ({stallF, stallD, flushD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
             mdu_busy, mdu_done} !== 12'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {stallF, stallD, flushD, flushE,
                     forwardAD, forwardBD, forwardAE, forwardBE, mdu_busy, mdu_done});
        end
        total++;
        if (stall_cnt !== '0) begin
            bad++;
            $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_forward();
        clear_inputs();
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1;
        @(negedge clk);
        total++;
        if (forwardAE !== 2'b10) begin
            bad++; $display("FAIL fwd_mem got=%b exp=10", forwardAE);
        end
        regwriteM = 1'b0;
        @(negedge clk);
        total++;
        if (forwardAE !== 2'b01) begin
            bad++; $display("FAIL fwd_wb got=%b exp=01", forwardAE);
        end
        rsE = 5'd0; rtE = 5'd0; writeregW = 5'd0;
        @(negedge clk);
        total++;
        if (forwardAE !== 2'b00 || forwardBE !== 2'b00) begin
            bad++; $display("FAIL fwd_zero got=%b/%b exp=00/00", forwardAE, forwardBE);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        memtoregE = 1'b1; writeregE = 5'd5; rtD = 5'd5; pcsrcD = 1'b1;
        @(negedge clk);
        total++;
        if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin
            bad++;
            $display("FAIL lw_stall got=%b exp=1110", {stallF, stallD, flushE, flushD});
        end
        tick();
        memtoregE = 1'b0; pcsrcD = 1'b0;
        @(negedge clk);
        total++;
        if (stall_cnt !== 4'd1) begin
            bad++; $display("FAIL lw_stall_cnt got=%0d exp=1", stall_cnt);
        end
        total++;
        if ({stallF, stallD, flushE, flushD} !== 4'b0000) begin
            bad++;
            $display("FAIL lw_release got=%b exp=0000", {stallF, stallD, flushE, flushD});
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        branchD = 1'b1; rsD = 5'd7; regwriteE = 1'b1; writeregE = 5'd7;
        @(negedge clk);
        total++;
        if (stallD !== 1'b1) begin
            bad++; $display("FAIL br_stall_e got=%b exp=1", stallD);
        end
        tick();
        regwriteE = 1'b0; memtoregM = 1'b1; writeregM = 5'd7; regwriteM = 1'b1;
        @(negedge clk);
        total++;
        if (stallD !== 1'b1) begin
            bad++; $display("FAIL br_stall_m got=%b exp=1", stallD);
        end
        tick();
        memtoregM = 1'b0; pcsrcD = 1'b1;
        @(negedge clk);
        total++;
        if ({forwardAD, flushD, stallF} !== 3'b110) begin
            bad++;
            $display("FAIL br_fwd_flush got=%b exp=110", {forwardAD, flushD, stallF});
        end
        tick();
    endtask

    task automatic test_mdu();
        do_reset();
        hiloreadD = 1'b1; mdstartE = 1'b1;
        @(negedge clk);
        total++;
        if ({stallD, mdu_busy, mdu_done} !== 3'b100) begin
            bad++;
            $display("FAIL mdu_start got=%b exp=100", {stallD, mdu_busy, mdu_done});
        end
        tick();
        mdstartE = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            total++;
            if ({stallD, mdu_busy, mdu_done} !== {2'b11, (i == LAT)}) begin
                bad++;
                $display("FAIL mdu_busy_%0d got=%b exp=%b", i, {stallD, mdu_busy, mdu_done},
                         {2'b11, (i == LAT)});
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({stallD, mdu_busy, mdu_done} !== 3'b000) begin
            bad++;
            $display("FAIL mdu_release got=%b exp=000", {stallD, mdu_busy, mdu_done});
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
        hiloreadD = 1'b1;
        repeat (2) tick();
        // cnt is now 2: pull reset between edges
        memtoregE = 1'b1; writeregE = 5'd4; rsD = 5'd4;
        rsE = 5'd4; writeregM = 5'd4; regwriteM = 1'b1; pcsrcD = 1'b1;
        reset = 1'b1;
        last_start = -1000;
        m_scnt = 0;
        #1;
        total++;
        if (mdu_busy !== 1'b0 || stall_cnt !== '0) begin
            bad++; $display("FAIL rst_async got busy=%b cnt=%0d exp 0/0", mdu_busy, stall_cnt);
        end
        @(negedge clk);
        total++;
        if ({stallF, stallD, flushD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
             mdu_busy, mdu_done} !== 12'b0) begin
            bad++;
            $display("FAIL rst_hold got=%b exp=0", {stallF, stallD, flushD, flushE,
                     forwardAD, forwardBD, forwardAE, forwardBE, mdu_busy, mdu_done});
        end
        tick();
        reset = 1'b0;
        memtoregE = 1'b0; pcsrcD = 1'b0;
        @(negedge clk);
        total++;
        if ({stallD, mdu_busy, forwardAE} !== 4'b0010) begin
            bad++;
            $display("FAIL rst_resume got=%b exp=0010", {stallD, mdu_busy, forwardAE});
        end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] got, exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            memtoregE = ($urandom_range(0, 3) == 0);
            memtoregM = ($urandom_range(0, 3) == 0);
            branchD   = ($urandom_range(0, 2) == 0);
            pcsrcD    = 1'($urandom);
            mdstartD  = ($urandom_range(0, 5) == 0);
            hiloreadD = ($urandom_range(0, 5) == 0);
            mdstartE  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            model_eval();
            got = {stallF, stallD, flushD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
                   mdu_busy, mdu_done};
            exp = {e_stall, e_stall, e_flushD, e_stall, e_fAD, e_fBD, e_fAE, e_fBE,
                   e_busy, e_done};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL rnd_outputs cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            total++;
            if (stall_cnt !== CW'(m_scnt)) begin
                bad++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_scnt);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        memtoregE = 1'b1; writeregE = 5'd9; rsD = 5'd9;
        repeat (20) tick();
        clear_inputs();
        @(negedge clk);
        total++;
        if (stall_cnt !== 4'd15 || m_scnt != SAT) begin
            bad++; $display("FAIL sat_stall_cnt got=%0d exp=15", stall_cnt);
        end
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mdu();
        test_reset_mid_op();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
